cc_miss_issue_unit: RTL and testbench

- Sits between the cache tag-compare/data-SRAM lookup stage and the data reorder unit.
- For each looked-up request it pushes one hit flag into the reorder unit's hit-flag FIFO (1 = hit, 0 = miss).
  - On a hit it also pushes the line plus the word offset into the hit-data FIFO.
  - On a miss it issues an AXI wrap read (critical word first) to memory.
- It snoops the accepted memory R beats, reassembles each missed line in address order, and emits a one-cycle refill write toward the tag/data arrays.

---
 rtl/cc_miss_issue_unit.sv | 165 ++++++++++++++++
 tb/tb_cc_miss_issue_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_issue_unit.sv
// cc_miss_issue_unit
//   Sits between the cache lookup stage and the data reorder unit. Each
//   accepted lookup pushes one hit flag (1 = hit, 0 = miss) into the reorder
//   unit's hit-flag FIFO. Hits also push {word offset, line} into the hit-data
//   FIFO. Misses issue an AXI WRAP read (critical word first) and are queued.
//   Accepted R beats are snooped and reassembled in address order into a line
//   buffer. A one-cycle refill write is emitted after the last beat.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req_*                    lookup result handshake, address, hit, line data
//   hit_flag_fifo_*          hit-flag FIFO push side (afull in, wren/wdata out)
//   hit_data_fifo_*          hit-data FIFO push side, wdata = {addr[5:0], line}
//   mem_ar*                  AXI read address channel (len 7, size 8B, WRAP)
//   mem_r*                   snooped AXI read data channel
//   refill_*                 refill write toward the tag/data arrays
module cc_miss_issue_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned INDEX_W     = 9,
  parameter int unsigned MISSQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic                        req_hit_i,
  input  logic [511:0]                req_data_i,
  input  logic                        hit_flag_fifo_afull_i,
  output logic                        hit_flag_fifo_wren_o,
  output logic                        hit_flag_fifo_wdata_o,
  input  logic                        hit_data_fifo_afull_i,
  output logic                        hit_data_fifo_wren_o,
  output logic [517:0]                hit_data_fifo_wdata_o,
  output logic [ADDR_W-1:0]           mem_araddr_o,
  output logic [3:0]                  mem_arlen_o,
  output logic [2:0]                  mem_arsize_o,
  output logic [1:0]                  mem_arburst_o,
  output logic                        mem_arvalid_o,
  input  logic                        mem_arready_i,
  input  logic [63:0]                 mem_rdata_i,
  input  logic                        mem_rlast_i,
  input  logic                        mem_rvalid_i,
  input  logic                        mem_rready_i,
  output logic                        refill_wren_o,
  output logic [INDEX_W-1:0]          refill_index_o,
  output logic [ADDR_W-INDEX_W-7:0]   refill_tag_o,
  output logic [511:0]                refill_data_o
);

  localparam int unsigned PTR_W = (MISSQ_DEPTH > 1) ? $clog2(MISSQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MISSQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // AR register
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;

  // Miss queue
  logic [ADDR_W-1:0] r_mq [MISSQ_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // Reassembly
  logic [2:0]        r_beat;
  logic              r_refill;
  logic [7:0][63:0]  r_line;

  logic              w_mq_full;
  logic              w_ready;
  logic              w_xfer;
  logic              w_hit_xfer;
  logic              w_miss_xfer;
  logic              w_beat;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [2:0]        w_beat_word;
  logic [2:0]        w_slot;

  // ar_pending is exactly the AR register being occupied: set the cycle after
  // the accepted miss, cleared the cycle after the handshake.
  assign w_mq_full   = (r_cnt == CNT_FULL);
  assign w_ready     = rst_n && !hit_flag_fifo_afull_i &&
                       (req_hit_i ? !hit_data_fifo_afull_i : (!r_arvalid && !w_mq_full));
  assign w_xfer      = req_valid_i && w_ready;
  assign w_hit_xfer  = w_xfer && req_hit_i;
  assign w_miss_xfer = w_xfer && !req_hit_i;

  assign req_ready_o           = w_ready;
  assign hit_flag_fifo_wren_o  = w_xfer;
  assign hit_flag_fifo_wdata_o = w_hit_xfer;
  assign hit_data_fifo_wren_o  = w_hit_xfer;
  assign hit_data_fifo_wdata_o = w_hit_xfer ? {req_addr_i[5:0], req_data_i} : '0;

  assign mem_araddr_o  = r_araddr;
  assign mem_arvalid_o = r_arvalid;
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'b011;
  assign mem_arburst_o = 2'b10;

  // During the refill cycle the head is still the line being written out, so
  // a beat arriving then belongs to the following entry (slot k=0); it only
  // counts if such an entry exists.
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
  assign w_beat       = mem_rvalid_i && mem_rready_i &&
                        (r_refill ? (r_cnt > CNT_ONE) : (r_cnt != '0));
  assign w_beat_word  = r_refill ? r_mq[w_rd_ptr_nxt][5:3] : r_mq[r_rd_ptr][5:3];
  assign w_slot       = w_beat_word + (r_refill ? 3'd0 : r_beat);

  assign refill_wren_o  = r_refill;
  assign refill_index_o = r_refill ? r_mq[r_rd_ptr][INDEX_W+5:6] : '0;
  assign refill_tag_o   = r_refill ? r_mq[r_rd_ptr][ADDR_W-1:INDEX_W+6] : '0;
  assign refill_data_o  = r_refill ? r_line : '0;

  always_ff @(posedge clk) begin
    if (w_miss_xfer) begin
      r_mq[r_wr_ptr] <= req_addr_i;
    end
    if (w_beat) begin
      r_line[w_slot] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_beat    <= '0;
      r_refill  <= 1'b0;
    end else begin
      if (w_miss_xfer) begin
        r_arvalid <= 1'b1;
        r_araddr  <= {req_addr_i[ADDR_W-1:3], 3'b000};
      end else if (r_arvalid && mem_arready_i) begin
        r_arvalid <= 1'b0;
      end

      r_refill <= w_beat && mem_rlast_i;

      if (r_refill) begin
        r_beat <= w_beat ? 3'd1 : 3'd0;
      end else if (w_beat) begin
        r_beat <= r_beat + 3'd1;
      end

      if (w_miss_xfer) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (r_refill) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end

      case ({w_miss_xfer, r_refill})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_miss_issue_unit.sv
// Directed self-checking bench for cc_miss_issue_unit.
module tb_cc_miss_issue_unit;

  logic         clk;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  req_addr_i;
  logic         req_hit_i;
  logic [511:0] req_data_i;
  logic         hit_flag_fifo_afull_i;
  logic         hit_flag_fifo_wren_o;
  logic         hit_flag_fifo_wdata_o;
  logic         hit_data_fifo_afull_i;
  logic         hit_data_fifo_wren_o;
  logic [517:0] hit_data_fifo_wdata_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i;
  logic [63:0]  mem_rdata_i;
  logic         mem_rlast_i;
  logic         mem_rvalid_i;
  logic         mem_rready_i;
  logic         refill_wren_o;
  logic [8:0]   refill_index_o;
  logic [16:0]  refill_tag_o;
  logic [511:0] refill_data_o;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  logic [511:0] pat;
  logic [511:0] exp_line;

  cc_miss_issue_unit #(.ADDR_W(32), .INDEX_W(9), .MISSQ_DEPTH(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_addr_i            (req_addr_i),
    .req_hit_i             (req_hit_i),
    .req_data_i            (req_data_i),
    .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
    .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
    .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
    .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
    .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arsize_o          (mem_arsize_o),
    .mem_arburst_o         (mem_arburst_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rdata_i           (mem_rdata_i),
    .mem_rlast_i           (mem_rlast_i),
    .mem_rvalid_i          (mem_rvalid_i),
    .mem_rready_i          (mem_rready_i),
    .refill_wren_o         (refill_wren_o),
    .refill_index_o        (refill_index_o),
    .refill_tag_o          (refill_tag_o),
    .refill_data_o         (refill_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [543:0] obs, input logic [543:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bd(input int unsigned s, input int unsigned k);
    return {32'(s), 32'(k) ^ 32'hA5A5_0000};
  endfunction

  // Drive a full 8-beat line (seed s) for a miss at word w; build expected line.
  task automatic send_line(input int unsigned s, input int unsigned w);
    exp_line = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k == 4) begin
        // stalled beat: rvalid without rready must not land
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b0;
        mem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
        mem_rlast_i  = 1'b1;
        step();
      end
      mem_rvalid_i = 1'b1;
      mem_rready_i = 1'b1;
      mem_rdata_i  = bd(s, k);
      mem_rlast_i  = (k == 7);
      exp_line[((w + k) % 8) * 64 +: 64] = bd(s, k);
      step();
    end
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] a);
    req_valid_i = 1'b1;
    req_hit_i   = 1'b0;
    req_addr_i  = a;
    #1;
    chk("miss_ready", req_ready_o, 1'b1);
    step();
    req_valid_i   = 1'b0;
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_hit_i = 1'b0; req_data_i = '0;
    hit_flag_fifo_afull_i = 1'b0; hit_data_fifo_afull_i = 1'b0;
    mem_arready_i = 1'b0; mem_rdata_i = '0; mem_rlast_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0;
    step();
    step();

    // Reset state
    req_valid_i = 1'b1; req_hit_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_flag_wren", hit_flag_fifo_wren_o, 1'b0);
    chk("rst_data_wren", hit_data_fifo_wren_o, 1'b0);
    chk("rst_arvalid", mem_arvalid_o, 1'b0);
    chk("rst_refill", refill_wren_o, 1'b0);
    req_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    // Single hit
    pat = {8{64'h0123_4567_89AB_CDEF}};
    req_addr_i = 32'h0000_1048; req_hit_i = 1'b1; req_data_i = pat; req_valid_i = 1'b1;
    #1;
    chk("hit_ready", req_ready_o, 1'b1);
    chk("hit_flag_wren", hit_flag_fifo_wren_o, 1'b1);
    chk("hit_flag_wdata", hit_flag_fifo_wdata_o, 1'b1);
    chk("hit_data_wren", hit_data_fifo_wren_o, 1'b1);
    chk("hit_data_wdata", hit_data_fifo_wdata_o, {6'h08, pat});
    step();
    req_valid_i = 1'b0;
    #1;
    chk("hit_no_ar", mem_arvalid_o, 1'b0);

    // Single miss, AR stalled 3 cycles
    req_addr_i = 32'h0000_2058; req_hit_i = 1'b0; req_valid_i = 1'b1;
    #1;
    chk("miss_ready", req_ready_o, 1'b1);
    chk("miss_flag_wren", hit_flag_fifo_wren_o, 1'b1);
    chk("miss_flag_wdata", hit_flag_fifo_wdata_o, 1'b0);
    chk("miss_data_wren", hit_data_fifo_wren_o, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      req_addr_i = 32'h0000_3000; req_hit_i = 1'b0; req_valid_i = 1'b1;
      #1;
      chk("ar_valid_held", mem_arvalid_o, 1'b1);
      chk("ar_addr_held", mem_araddr_o, 32'h0000_2058);
      chk("ar_len", mem_arlen_o, 4'd7);
      chk("ar_size", mem_arsize_o, 3'b011);
      chk("ar_burst", mem_arburst_o, 2'b10);
      chk("ar_pending_ready", req_ready_o, 1'b0);
      chk("ar_pending_wren", hit_flag_fifo_wren_o, 1'b0);
      step();
    end
    req_valid_i = 1'b0;
    mem_arready_i = 1'b1;
    #1;
    chk("ar_hs_valid", mem_arvalid_o, 1'b1);
    step();
    mem_arready_i = 1'b0;
    #1;
    chk("ar_dropped", mem_arvalid_o, 1'b0);
    chk("ready_after_hs", req_ready_o, 1'b1);

    // Wrap refill of 0x2058 (word 3)
    send_line(1, 3);
    #1;
    chk("wrap_refill_wren", refill_wren_o, 1'b1);
    chk("wrap_refill_index", refill_index_o, 9'h081);
    chk("wrap_refill_tag", refill_tag_o, 17'h0);
    chk("wrap_refill_data", refill_data_o, exp_line);
    chk("wrap_refill_w3", refill_data_o[255:192], bd(1, 0));
    step();
    chk("wrap_refill_once", refill_wren_o, 1'b0);

    // Back-pressure
    hit_data_fifo_afull_i = 1'b1;
    req_valid_i = 1'b1; req_hit_i = 1'b1; req_addr_i = 32'h0000_1100;
    #1;
    chk("bp_hit_ready", req_ready_o, 1'b0);
    chk("bp_hit_flag_wren", hit_flag_fifo_wren_o, 1'b0);
    chk("bp_hit_data_wren", hit_data_fifo_wren_o, 1'b0);
    req_hit_i = 1'b0; req_addr_i = 32'h0000_4000;
    #1;
    chk("bp_miss_ready", req_ready_o, 1'b1);
    chk("bp_miss_flag_wren", hit_flag_fifo_wren_o, 1'b1);
    step();
    hit_data_fifo_afull_i = 1'b0;
    hit_flag_fifo_afull_i = 1'b1;
    req_hit_i = 1'b1;
    #1;
    chk("bp_flag_afull_ready", req_ready_o, 1'b0);
    chk("bp_flag_afull_dwren", hit_data_fifo_wren_o, 1'b0);
    hit_flag_fifo_afull_i = 1'b0;
    req_valid_i = 1'b0;
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;

    // Queue full
    do_miss(32'h0000_5008);
    do_miss(32'h0000_6010);
    do_miss(32'h0000_7018);
    req_valid_i = 1'b1; req_hit_i = 1'b0; req_addr_i = 32'h0000_9000;
    #1;
    chk("qfull_arvalid", mem_arvalid_o, 1'b0);
    chk("qfull_miss_ready", req_ready_o, 1'b0);
    req_hit_i = 1'b1;
    #1;
    chk("qfull_hit_ready", req_ready_o, 1'b1);
    chk("qfull_hit_flag", hit_flag_fifo_wdata_o, 1'b1);
    step();
    req_valid_i = 1'b0; req_hit_i = 1'b0;
    send_line(2, 0);
    #1;
    chk("qfull_refill_wren", refill_wren_o, 1'b1);
    chk("qfull_refill_index", refill_index_o, 9'h100);
    chk("qfull_refill_data", refill_data_o, exp_line);
    step();
    chk("qfull_reopen", req_ready_o, 1'b1);
    chk("qfull_refill_once", refill_wren_o, 1'b0);

    // Reset during beat 5 of the 0x5008 refill
    mem_rready_i = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = bd(9, k); mem_rlast_i = 1'b0;
      step();
    end
    mem_rdata_i = bd(9, 5);
    rst_n = 1'b0;
    req_valid_i = 1'b1; req_hit_i = 1'b1;
    step();
    chk("mrst_refill", refill_wren_o, 1'b0);
    chk("mrst_arvalid", mem_arvalid_o, 1'b0);
    chk("mrst_ready", req_ready_o, 1'b0);
    chk("mrst_flag_wren", hit_flag_fifo_wren_o, 1'b0);
    chk("mrst_data_wren", hit_data_fifo_wren_o, 1'b0);
    for (int unsigned k = 6; k < 8; k++) begin
      mem_rdata_i = bd(9, k); mem_rlast_i = (k == 7);
      step();
      chk("mrst_refill_hold", refill_wren_o, 1'b0);
    end
    req_valid_i = 1'b0; req_hit_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    rst_n = 1'b1;
    step();
    // Stray last beat with an empty queue is ignored
    mem_rvalid_i = 1'b1; mem_rlast_i = 1'b1; mem_rdata_i = bd(7, 7);
    step();
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    chk("empty_q_no_refill", refill_wren_o, 1'b0);
    step();
    chk("empty_q_no_refill2", refill_wren_o, 1'b0);

    // Fresh miss after reset, unaligned address in word 7
    req_valid_i = 1'b1; req_hit_i = 1'b0; req_addr_i = 32'h0000_803C;
    #1;
    chk("post_rst_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    mem_arready_i = 1'b1;
    #1;
    chk("post_rst_araddr", mem_araddr_o, 32'h0000_8038);
    step();
    mem_arready_i = 1'b0;
    send_line(3, 7);
    #1;
    chk("post_rst_refill_wren", refill_wren_o, 1'b1);
    chk("post_rst_refill_index", refill_index_o, 9'h000);
    chk("post_rst_refill_tag", refill_tag_o, 17'h1);
    chk("post_rst_refill_data", refill_data_o, exp_line);
    chk("post_rst_w7", refill_data_o[511:448], bd(3, 0));
    step();
    chk("post_rst_refill_once", refill_wren_o, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
